// File: rtl/seven_seg_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture_if
// Brief    : Display-line and capture-result bundle for seven_seg_capture.
//            master = display driver side, slave = capture block.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_seg_capture_if;
  logic [3:0] an;          // anode lines, active low
  logic [0:6] seg;         // segment lines, active low, seg[0]=a .. seg[6]=g
  logic [7:0] data_out;    // last completed frame {hi, lo}
  logic       data_valid;  // one-cycle pulse on data_out update
  logic       pattern_err; // one-cycle pulse on rejected stable sample
  logic       stale;       // no frame within the timeout window

  modport master (
    output an, seg,
    input  data_out, data_valid, pattern_err, stale
  );

  modport slave (
    input  an, seg,
    output data_out, data_valid, pattern_err, stale
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Brief    : Samples multiplexed active-low anode/segment lines, qualifies
//            each digit by stability, decodes it to a hex nibble and
//            assembles {hi, lo} frames. Flags malformed and missing traffic.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_capture_if.slave  bus
);

  localparam logic [7:0]  C_STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] C_TO_MAX   = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  C_AN_BLANK = 4'b1111;
  localparam logic [3:0]  C_AN_LO    = 4'b1110;
  localparam logic [3:0]  C_AN_HI    = 4'b1101;

  // Returns {legal, nibble}; legal=0 for any pattern outside the hex font.
  function automatic logic [4:0] decode(input logic [0:6] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // Sample pipeline: {an, seg} packed with seg[0] at bit 6.
  logic [10:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0]  stab_q, stab_d;
  logic        armed_q, armed_d;
  logic [3:0]  lo_q, lo_d, hi_q, hi_d;
  logic        got_lo_q, got_lo_d, got_hi_q, got_hi_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        pattern_err_q, pattern_err_d;
  logic [15:0] to_q, to_d;

  logic        changed;
  logic        accept;
  logic [3:0]  s_an;
  logic [0:6]  s_seg;
  logic [4:0]  dec;

  // Next-state: synchronizer, stability qualification, classification,
  // frame assembly and timeout counting.
  always_comb begin
    sync1_d       = {bus.an, bus.seg};
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    stab_d        = stab_q;
    armed_d       = armed_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    got_lo_d      = got_lo_q;
    got_hi_d      = got_hi_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    pattern_err_d = 1'b0;
    to_d          = to_q;

    s_an    = sync2_q[10:7];
    s_seg   = sync2_q[6:0];
    dec     = decode(s_seg);
    changed = (sync2_q != prev_q);

    if (changed) begin
      stab_d  = 8'd0;
      armed_d = 1'b1;
    end else if (stab_q != C_STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end

    // Accept exactly once, in the cycle the count reaches its target.
    accept = armed_q && !changed && (stab_d == C_STAB_MAX);
    if (accept) begin
      armed_d = 1'b0;
    end

    if (accept) begin
      case (s_an)
        C_AN_BLANK: ;
        C_AN_LO: begin
          if (dec[4]) begin
            lo_d     = dec[3:0];
            got_lo_d = 1'b1;
          end else begin
            pattern_err_d = 1'b1;
          end
        end
        C_AN_HI: begin
          if (dec[4]) begin
            hi_d     = dec[3:0];
            got_hi_d = 1'b1;
          end else begin
            pattern_err_d = 1'b1;
          end
        end
        default: pattern_err_d = 1'b1;
      endcase
    end

    // The completing nibble and the flag clear land on the same edge.
    if (got_lo_d && got_hi_d) begin
      data_out_d   = {hi_d, lo_d};
      data_valid_d = 1'b1;
      got_lo_d     = 1'b0;
      got_hi_d     = 1'b0;
    end

    if (data_valid_q) begin
      to_d = 16'd0;
    end else if (to_q != C_TO_MAX) begin
      to_d = to_q + 16'd1;
    end
  end

  // State register with synchronous reset; a partial frame is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      stab_q        <= '0;
      armed_q       <= 1'b0;
      lo_q          <= '0;
      hi_q          <= '0;
      got_lo_q      <= 1'b0;
      got_hi_q      <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      to_q          <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      armed_q       <= armed_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      got_lo_q      <= got_lo_d;
      got_hi_q      <= got_hi_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      pattern_err_q <= pattern_err_d;
      to_q          <= to_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.stale       = (to_q == C_TO_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_capture
// Brief    : Scoreboard bench for seven_seg_capture: directed digit dwells,
//            expected frames queued by the stimulus, checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

  localparam logic [3:0] AN_BLANK = 4'b1111;
  localparam logic [3:0] AN_LO    = 4'b1110;
  localparam logic [3:0] AN_HI    = 4'b1101;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100, PA = 7'b0001000, PC = 7'b0110001;
  localparam logic [6:0] PF = 7'b0111000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_capture_if bus();

  seven_seg_capture #(
    .STABLE_CYCLES (16),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int valid_times[$];
  int valid_cnt  = 0;
  int err_cnt    = 0;
  int stale_rise = 0;
  logic stale_at_valid    = 1'b0;
  logic stale_after_valid = 1'b1;
  logic prev_valid = 1'b0;
  logic prev_stale = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    bus.an  = a;
    bus.seg = s;
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.data_valid === 1'b1) begin
        valid_cnt++;
        valid_times.push_back(cyc);
        stale_at_valid = bus.stale;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got data_out 0x%0h, expected no frame", bus.data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {24'd0, bus.data_out}, {24'd0, e});
        end
      end
      if (prev_valid) stale_after_valid = bus.stale;
      if (bus.pattern_err === 1'b1) err_cnt++;
      if (bus.stale === 1'b1 && !prev_stale) stale_rise = cyc;
      prev_valid = bus.data_valid;
      prev_stale = bus.stale;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed dwells, pushing each expected frame ahead of its hi digit.
  initial begin
    int e0;
    int v0;
    rst     = 1'b1;
    bus.an  = AN_BLANK;
    bus.seg = SEG_OFF;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, bus.data_out}, 32'h00);
    check("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_pattern_err", {31'd0, bus.pattern_err}, 32'd0);
    check("rst_stale", {31'd0, bus.stale}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single frame 0xA3.
    hold(AN_LO, P3, 512);
    exp_q.push_back(8'hA3);
    hold(AN_HI, PA, 512);
    hold(AN_BLANK, SEG_OFF, 64);
    check("a3_valid_count", valid_cnt, 1);
    check("a3_no_err", err_cnt, 0);

    // Continuous alternation of 0x5F, 10 frames.
    valid_times.delete();
    for (int i = 0; i < 10; i++) begin
      hold(AN_LO, PF, 512);
      exp_q.push_back(8'h5F);
      hold(AN_HI, P5, 512);
    end
    hold(AN_BLANK, SEG_OFF, 64);
    check("5f_frames", valid_times.size(), 10);
    for (int i = 1; i < valid_times.size(); i++)
      check_range("5f_period", valid_times[i] - valid_times[i-1], 1020, 1028);

    // Short glitch dwell between lo and hi must not be accepted.
    e0 = err_cnt;
    hold(AN_LO, P7, 512);
    hold(AN_LO, P1, 8);
    exp_q.push_back(8'h27);
    hold(AN_HI, P2, 512);
    hold(AN_BLANK, SEG_OFF, 64);
    check("glitch_no_err", err_cnt - e0, 0);

    // Illegal segment pattern and illegal anode, each one error, no capture.
    e0 = err_cnt;
    hold(AN_LO, P1, 512);
    hold(AN_LO, 7'b1111110, 64);
    hold(4'b1100, P0, 64);
    check("illegal_err_count", err_cnt - e0, 2);
    check("illegal_data_hold", {24'd0, bus.data_out}, 32'h27);
    exp_q.push_back(8'hC1);
    hold(AN_HI, PC, 512);
    hold(AN_BLANK, SEG_OFF, 64);

    // Timeout: blank display long enough for stale to rise.
    hold(AN_BLANK, SEG_OFF, 5000);
    check_range("stale_delay", stale_rise - valid_times[valid_times.size()-1], 4096, 4097);
    check("stale_level", {31'd0, bus.stale}, 32'd1);
    hold(AN_LO, P8, 512);
    exp_q.push_back(8'h98);
    hold(AN_HI, P9, 512);
    hold(AN_BLANK, SEG_OFF, 8);
    check("stale_at_valid", {31'd0, stale_at_valid}, 32'd1);
    check("stale_after_valid", {31'd0, stale_after_valid}, 32'd0);
    check("stale_cleared", {31'd0, bus.stale}, 32'd0);

    // Reset after only the low digit: hi alone must not complete a frame.
    v0 = valid_cnt;
    hold(AN_LO, P4, 512);
    hold(AN_BLANK, SEG_OFF, 64);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_data_out", {24'd0, bus.data_out}, 32'h00);
    check("mid_rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("mid_rst_pattern_err", {31'd0, bus.pattern_err}, 32'd0);
    check("mid_rst_stale", {31'd0, bus.stale}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(AN_HI, P6, 512);
    hold(AN_BLANK, SEG_OFF, 64);
    check("post_rst_no_frame", valid_cnt - v0, 0);
    check("post_rst_data_out", {24'd0, bus.data_out}, 32'h00);

    check("pending_frames", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the two-digit multiplexed seven-segment driver: samples the active-low anode and segment lines and reconstructs the displayed 8-bit value.
- Used as an on-board loopback and self-check monitor. It also serves as a bench monitor that verifies display content without waveform inspection.
- Qualifies each digit by stability and decodes segment patterns back to hex nibbles. It assembles {high digit, low digit} frames and flags malformed or missing traffic.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples of {an, seg} required before a digit is accepted. Legal range 2..255.
- TIMEOUT_CYCLES, 4096: cycles without a completed frame before stale asserts. Legal range 16..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- an  input  4  anode lines, active low; 1110 = digit 0 (low nibble), 1101 = digit 1 (high nibble)
- seg  input  [0:6]  segment lines, active low; seg[0]=a through seg[6]=g
- data_out  output  8  last completed frame, {hi, lo}
- data_valid  output  1  one-cycle pulse when data_out updates
- pattern_err  output  1  one-cycle pulse on a rejected stable sample
- stale  output  1  level; high while no frame has completed within TIMEOUT_CYCLES

Behaviour:
- Input registering: an and seg pass through a 2-flop synchronizer before any logic. The "sample" is the second-stage value.
- Reset values: data_out=0x00, data_valid=0, pattern_err=0, stale=0. All internal counters, flags and the armed bit are cleared.
- Reset mid-frame: a partially captured frame is discarded.

Stability:
- stab_cnt (8 bit) clears to 0 whenever the sample differs from the previous cycle's sample. Otherwise it increments, saturating at STABLE_CYCLES-1.
- An armed bit is set on any sample change.
- The cycle stab_cnt reaches STABLE_CYCLES-1 with armed=1 is the accept cycle, and armed clears in that cycle.
- Exactly one accept occurs per stable dwell. A dwell shorter than STABLE_CYCLES produces no accept.

Accept classification:
- an=1111: blank. No action, no error.
- an=1110 or an=1101 with a legal pattern: the nibble goes to lo_reg or hi_reg respectively, and got_lo or got_hi is set.
- Any other an value, or an illegal seg pattern: pattern_err pulses for 1 cycle and the sample is discarded. The got flags are unchanged.

Decode table (seg[0..6], active low); any other pattern is illegal:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000
- C=0110001, d=1000010, E=0110000, F=0111000

Frame assembly:
- Frame complete is the cycle in which got_lo and got_hi are both set. An accept completes the frame in the same cycle as its own nibble write.
- Latency: data_out updates and data_valid pulses on the clock edge following the completing accept.
- Both got flags clear at frame completion. The new nibble and the flag clear happen in the same edge.
- A repeated digit before frame completion (e.g. lo, lo, hi) overwrites that nibble; the last value wins.
- data_valid pulses on every frame, even if the value is unchanged.

Timeout:
- to_cnt (16 bit) clears on data_valid; otherwise it increments, saturating at TIMEOUT_CYCLES.
- stale = (to_cnt == TIMEOUT_CYCLES).
- stale deasserts in the cycle after the next data_valid.

Test Plan:
- Drive an=1110/seg=0000110 for 512 cycles, then an=1101/seg=0001000 for 512 cycles -> single data_valid pulse with data_out=0xA3, pattern_err never asserted.
- Continuous driver-style alternation of 0x5F with 512-cycle dwell, 10 frames -> data_valid every 1024 cycles (±4 cycles synchronizer/stability latency), data_out=0x5F each time.
- Glitch: 8-cycle dwell an=1110/seg=1001111 inserted mid-stream -> no accept, no pattern_err, next frame value unaffected.
- Illegal inputs, each held 64 cycles: seg=1111110, then an=1100 -> exactly one pattern_err pulse per dwell, got flags and data_out unchanged.
- Hold an=1111 after a frame for 5000 cycles -> stale=1 from cycle 4096 after data_valid. The next valid frame clears stale one cycle after its data_valid.
- Assert rst for 1 cycle after only the low digit is captured -> all outputs 0, and the following high digit alone produces no data_valid.
